ft245_fifo_responder: RTL and testbench

- Synthesizable FPGA-side model of the FT232H chip's async 245 FIFO interface, i.e. the chip end of the bus that our USB controller drives.
- Presents RXF#, TXE# and the bidirectional data bus to a controller. Accepts RD#/WR# strobes.
- Internally buffers a host->FPGA byte queue (RX FIFO) and an FPGA->host byte queue (TX FIFO).
- Used for on-chip loopback and for bench verification of the controller without hardware.

---
 rtl/ft245_pkg.sv | 24 ++
 rtl/ft245_fifo_responder_if.sv | 22 ++
 rtl/ft245_sync_fifo.sv | 59 +++++
 rtl/ft245_fifo_responder.sv | 183 ++++++++++++++++++
 tb/tb_ft245_fifo_responder.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_pkg.sv
// rtl/ft245_pkg.sv - shared FSM states, error bit indices and default sizing for the FT245 responder
package ft245_pkg;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ARMED,
      R_DRIVE,
      R_RECOVER
   } rd_state_e;

   typedef enum logic {
      W_READY,
      W_RECOVER
   } wr_state_e;

   localparam int ERR_OVF = 0;
   localparam int ERR_UNF = 1;
   localparam int ERR_COL = 2;

   localparam int DEF_DEPTH_LOG2   = 4;
   localparam int DEF_RXF_RECOVERY = 2;
   localparam int DEF_TXE_RECOVERY = 2;

endpackage

// File: rtl/ft245_fifo_responder_if.sv
// rtl/ft245_fifo_responder_if.sv - async 245 bus between a USB controller (master) and the chip model (slave)
interface ft245_fifo_responder_if;

   logic       rd_n;
   logic       wr_n;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;
   logic       rxf_n;
   logic       txe_n;

   modport master (
      output rd_n, wr_n, data_in,
      input  data_out, data_oe, rxf_n, txe_n
   );

   modport slave (
      input  rd_n, wr_n, data_in,
      output data_out, data_oe, rxf_n, txe_n
   );

endinterface

// File: rtl/ft245_sync_fifo.sv
// rtl/ft245_sync_fifo.sv - 8-bit synchronous FIFO with first-word-fall-through head
module ft245_sync_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] push_data_i,
   input  logic       pop_i,
   output logic [7:0] head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; the pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/ft245_fifo_responder.sv
// rtl/ft245_fifo_responder.sv - FT232H async 245 FIFO chip-side model with host-side RX/TX byte queues
// Define FT245_SYNC_INPUTS_EN to pass rd_n/wr_n/data_in through 2-flop synchronizers.
module ft245_fifo_responder
   import ft245_pkg::*;
#(
   parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
   parameter int RXF_RECOVERY = DEF_RXF_RECOVERY,
   parameter int TXE_RECOVERY = DEF_TXE_RECOVERY
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   ft245_fifo_responder_if.slave bus,
   input  logic [7:0] host_tx_data,
   input  logic       host_tx_valid,
   output logic       host_tx_ready,
   output logic [7:0] host_rx_data,
   output logic       host_rx_valid,
   input  logic       host_rx_ready,
   output logic [2:0] err_flags
);

   localparam logic [7:0] RXF_LOAD = 8'(RXF_RECOVERY);
   localparam logic [7:0] TXE_LOAD = 8'(TXE_RECOVERY);

   logic       rd_s, wr_s;
   logic [7:0] din_s;

`ifdef FT245_SYNC_INPUTS_EN
   logic [1:0] rd_sync_q, wr_sync_q;
   logic [7:0] din_meta_q, din_sync_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rd_sync_q  <= 2'b11;
         wr_sync_q  <= 2'b11;
         din_meta_q <= '0;
         din_sync_q <= '0;
      end else begin
         rd_sync_q  <= {rd_sync_q[0], bus.rd_n};
         wr_sync_q  <= {wr_sync_q[0], bus.wr_n};
         din_meta_q <= bus.data_in;
         din_sync_q <= din_meta_q;
      end
   end

   assign rd_s  = rd_sync_q[1];
   assign wr_s  = wr_sync_q[1];
   assign din_s = din_sync_q;
`else
   assign rd_s  = bus.rd_n;
   assign wr_s  = bus.wr_n;
   assign din_s = bus.data_in;
`endif

   logic       rd_q, wr_q;
   logic       rd_fall, rd_rise, wr_fall, collision;
   rd_state_e  r_state_q, r_state_d;
   wr_state_e  w_state_q, w_state_d;
   logic [7:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;
   logic [2:0] err_q, err_d;
   logic       rx_pop, tx_push, rx_full, rx_empty, tx_full, tx_empty;
   logic       rxf_n_c, txe_n_c, oe_c;
   logic [7:0] rx_head;

   assign rd_fall   = rd_q & ~rd_s;
   assign rd_rise   = ~rd_q & rd_s;
   assign wr_fall   = wr_q & ~wr_s;
   assign collision = ~rd_s & ~wr_s;

   ft245_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .push_i      (host_tx_valid),
      .push_data_i (host_tx_data),
      .pop_i       (rx_pop),
      .head_o      (rx_head),
      .full_o      (rx_full),
      .empty_o     (rx_empty)
   );

   ft245_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clk_i       (CLOCK_50),
      .rst_i       (reset),
      .push_i      (tx_push),
      .push_data_i (din_s),
      .pop_i       (host_rx_ready),
      .head_o      (host_rx_data),
      .full_o      (tx_full),
      .empty_o     (tx_empty)
   );

   assign host_tx_ready = ~rx_full;
   assign host_rx_valid = ~tx_empty;

   always_comb begin
      r_state_d = r_state_q;
      rcnt_d    = rcnt_q;
      rx_pop    = 1'b0;
      rxf_n_c   = 1'b1;
      oe_c      = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (!rx_empty) r_state_d = R_ARMED;
         end
         R_ARMED: begin
            rxf_n_c = 1'b0;
            oe_c    = ~rd_s;
            if (rd_fall) r_state_d = R_DRIVE;
         end
         R_DRIVE: begin
            rxf_n_c = 1'b0;
            oe_c    = ~rd_s;
            if (rd_rise) begin
               rx_pop    = 1'b1;
               rxf_n_c   = 1'b1;
               rcnt_d    = RXF_LOAD;
               r_state_d = R_RECOVER;
            end
         end
         R_RECOVER: begin
            if (rcnt_q <= 8'd1) r_state_d = R_IDLE;
            else                rcnt_d    = rcnt_q - 8'd1;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // A colliding write strobe is swallowed: no push and no recovery window.
   always_comb begin
      w_state_d = w_state_q;
      wcnt_d    = wcnt_q;
      tx_push   = 1'b0;
      txe_n_c   = ~((w_state_q == W_READY) && !tx_full);
      unique case (w_state_q)
         W_READY: begin
            if (wr_fall && !txe_n_c && !collision) begin
               tx_push   = 1'b1;
               wcnt_d    = TXE_LOAD;
               w_state_d = W_RECOVER;
            end
         end
         W_RECOVER: begin
            if (wcnt_q <= 8'd1) w_state_d = W_READY;
            else                wcnt_d    = wcnt_q - 8'd1;
         end
         default: w_state_d = W_READY;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (wr_fall && txe_n_c)                err_d[ERR_OVF] = 1'b1;
      if (rd_fall && (r_state_q != R_ARMED)) err_d[ERR_UNF] = 1'b1;
      if (collision)                         err_d[ERR_COL] = 1'b1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rd_q      <= 1'b1;
         wr_q      <= 1'b1;
         r_state_q <= R_IDLE;
         w_state_q <= W_READY;
         rcnt_q    <= '0;
         wcnt_q    <= '0;
         err_q     <= '0;
      end else begin
         rd_q      <= rd_s;
         wr_q      <= wr_s;
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rcnt_q    <= rcnt_d;
         wcnt_q    <= wcnt_d;
         err_q     <= err_d;
      end
   end

   assign bus.data_out = rx_head;
   assign bus.data_oe  = oe_c;
   assign bus.rxf_n    = rxf_n_c;
   assign bus.txe_n    = txe_n_c;
   assign err_flags    = err_q;

endmodule

// File: tb/tb_ft245_fifo_responder.sv
// tb/tb_ft245_fifo_responder.sv - directed self-checking bench for ft245_fifo_responder
module tb_ft245_fifo_responder;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
   logic [2:0] err_flags;
   logic [7:0] got;
   int         checks = 0;
   int         errors = 0;

   ft245_fifo_responder_if bus ();

   ft245_fifo_responder dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .bus           (bus),
      .host_tx_data  (host_tx_data),
      .host_tx_valid (host_tx_valid),
      .host_tx_ready (host_tx_ready),
      .host_rx_data  (host_rx_data),
      .host_rx_valid (host_rx_valid),
      .host_rx_ready (host_rx_ready),
      .err_flags     (err_flags)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic smp();
      @(negedge CLOCK_50);
   endtask

   task automatic ctl_write(input logic [7:0] b);
      cyc();
      bus.wr_n    = 1'b0;
      bus.data_in = b;
      cyc();
      bus.wr_n = 1'b1;
      repeat (3) cyc();
   endtask

   task automatic wait_rxf();
      int n = 0;
      smp();
      while (bus.rxf_n && n < 20) begin
         cyc();
         smp();
         n++;
      end
      check("rxf_wait", 8'(bus.rxf_n), 8'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.rd_n      = 1'b1;
      bus.wr_n      = 1'b1;
      bus.data_in   = 8'h00;
      host_tx_data  = 8'h00;
      host_tx_valid = 1'b0;
      host_rx_ready = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;

      smp();
      check("rst_rxf", 8'(bus.rxf_n), 8'd1);
      check("rst_txe", 8'(bus.txe_n), 8'd0);
      check("rst_oe", 8'(bus.data_oe), 8'd0);
      check("rst_err", 8'(err_flags), 8'd0);
      check("rst_hrv", 8'(host_rx_valid), 8'd0);
      check("rst_htr", 8'(host_tx_ready), 8'd1);
      repeat (3) begin
         cyc();
         smp();
         check("idle_rxf", 8'(bus.rxf_n), 8'd1);
         check("idle_txe", 8'(bus.txe_n), 8'd0);
      end

      // single host byte read back by the controller
      cyc();
      host_tx_valid = 1'b1;
      host_tx_data  = 8'hA5;
      cyc();
      host_tx_valid = 1'b0;
      smp();
      check("rxf_lat1", 8'(bus.rxf_n), 8'd1);
      cyc();
      smp();
      check("rxf_armed", 8'(bus.rxf_n), 8'd0);
      check("oe_armed_idle", 8'(bus.data_oe), 8'd0);
      cyc();
      bus.rd_n = 1'b0;
      smp();
      check("oe_fall", 8'(bus.data_oe), 8'd1);
      check("dout_fall", bus.data_out, 8'hA5);
      cyc();
      smp();
      check("oe_drive", 8'(bus.data_oe), 8'd1);
      check("dout_drive", bus.data_out, 8'hA5);
      check("rxf_drive", 8'(bus.rxf_n), 8'd0);
      cyc();
      bus.rd_n = 1'b1;
      smp();
      check("rxf_rise", 8'(bus.rxf_n), 8'd1);
      check("oe_rise", 8'(bus.data_oe), 8'd0);
      repeat (4) begin
         cyc();
         smp();
         check("rxf_after", 8'(bus.rxf_n), 8'd1);
      end

      // single controller write
      cyc();
      bus.wr_n    = 1'b0;
      bus.data_in = 8'h3C;
      smp();
      check("txe_pre", 8'(bus.txe_n), 8'd0);
      cyc();
      bus.wr_n    = 1'b1;
      bus.data_in = 8'h00;
      smp();
      check("txe_rec1", 8'(bus.txe_n), 8'd1);
      check("hrv_3c", 8'(host_rx_valid), 8'd1);
      check("hrd_3c", host_rx_data, 8'h3C);
      cyc();
      smp();
      check("txe_rec2", 8'(bus.txe_n), 8'd1);
      cyc();
      smp();
      check("txe_back", 8'(bus.txe_n), 8'd0);
      cyc();
      host_rx_ready = 1'b1;
      cyc();
      host_rx_ready = 1'b0;
      smp();
      check("hrv_drained", 8'(host_rx_valid), 8'd0);

      // fill the TX FIFO, then overflow it
      for (int k = 0; k < 16; k++) ctl_write(8'(8'h40 + k));
      smp();
      check("txe_full", 8'(bus.txe_n), 8'd1);
      check("err_prefull", 8'(err_flags), 8'd0);
      ctl_write(8'hEE);
      smp();
      check("err_ovf", 8'(err_flags), 8'h01);
      cyc();
      host_rx_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         smp();
         check("drain_valid", 8'(host_rx_valid), 8'd1);
         check("drain_data", host_rx_data, 8'(8'h40 + k));
         cyc();
      end
      host_rx_ready = 1'b0;
      smp();
      check("drain_empty", 8'(host_rx_valid), 8'd0);
      check("txe_drained", 8'(bus.txe_n), 8'd0);

      // underrun
      cyc();
      bus.rd_n = 1'b0;
      smp();
      check("oe_unf", 8'(bus.data_oe), 8'd0);
      cyc();
      bus.rd_n = 1'b1;
      smp();
      check("err_unf", 8'(err_flags), 8'h03);

      // collision
      cyc();
      bus.rd_n    = 1'b0;
      bus.wr_n    = 1'b0;
      bus.data_in = 8'h99;
      smp();
      check("oe_col", 8'(bus.data_oe), 8'd0);
      cyc();
      bus.rd_n = 1'b1;
      bus.wr_n = 1'b1;
      smp();
      check("err_col", 8'(err_flags), 8'h07);
      check("col_nopush", 8'(host_rx_valid), 8'd0);
      repeat (3) cyc();
      smp();
      check("col_nopush2", 8'(host_rx_valid), 8'd0);
      check("col_txe", 8'(bus.txe_n), 8'd0);

      // three bytes queued, reset lands mid-read of the second
      cyc();
      host_tx_valid = 1'b1;
      host_tx_data  = 8'h11;
      cyc();
      host_tx_data  = 8'h22;
      cyc();
      host_tx_data  = 8'h33;
      cyc();
      host_tx_valid = 1'b0;

      wait_rxf();
      cyc();
      bus.rd_n = 1'b0;
      smp();
      check("rd1_oe", 8'(bus.data_oe), 8'd1);
      got = bus.data_out;
      check("rd1_data", got, 8'h11);
      cyc();
      cyc();
      bus.rd_n = 1'b1;

      wait_rxf();
      cyc();
      bus.rd_n = 1'b0;
      cyc();
      smp();
      check("rd2_oe", 8'(bus.data_oe), 8'd1);
      check("rd2_data", bus.data_out, 8'h22);
      cyc();
      reset = 1'b1;
      cyc();
      bus.rd_n = 1'b1;
      cyc();
      reset = 1'b0;
      smp();
      check("rr_rxf", 8'(bus.rxf_n), 8'd1);
      check("rr_oe", 8'(bus.data_oe), 8'd0);
      check("rr_err", 8'(err_flags), 8'd0);
      check("rr_hrv", 8'(host_rx_valid), 8'd0);
      check("rr_htr", 8'(host_tx_ready), 8'd1);
      check("rr_txe", 8'(bus.txe_n), 8'd0);
      repeat (3) begin
         cyc();
         smp();
         check("rr_rxf_hold", 8'(bus.rxf_n), 8'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
